// File: rtl/pifo_pop_sched_pkg.sv
// Shared constants and helpers for the PIFO pop-side scheduler.
package pifo_pop_sched_pkg;
  localparam int CNT_W         = 32;
  localparam int PRIORITY_BITS = 8;
  localparam int ELEMENT_BITS  = 16;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_BACKOFF   = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pifo_pop_sched_if.sv
// PIFO pop port: request from the scheduler, response one cycle later from the PIFO.
interface pifo_pop_sched_if
  import pifo_pop_sched_pkg::*;
#(
  parameter int BITPORT = 1,
  parameter int BITPRIO = PRIORITY_BITS,
  parameter int BITDATA = ELEMENT_BITS
);
  logic               pop_0;
  logic [BITPORT-1:0] oprt_0;
  logic               ovld_0;
  logic [BITPRIO-1:0] opri_0;
  logic [BITDATA-1:0] odout_0;

  modport master (output pop_0, oprt_0, input ovld_0, opri_0, odout_0);
  modport slave  (input pop_0, oprt_0, output ovld_0, opri_0, odout_0);
endinterface

// File: rtl/pifo_out_fifo.sv
// Per-port circular output buffer; head is visible combinationally.
module pifo_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_rd,
  output logic                   o_vld,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_occ
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_occ;
  logic          w_rd;

  assign o_occ   = r_occ;
  assign o_vld   = (r_occ != '0);
  assign w_rd    = i_rd && o_vld;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (i_wr && !rst) r_mem[r_wptr] <= i_wdata;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (i_wr && !w_rd)      r_occ <= r_occ + 1'b1;
      else if (!i_wr && w_rd) r_occ <= r_occ - 1'b1;
    end
  end
endmodule

// File: rtl/pifo_pop_sched.sv
// Round-robin pop scheduler: issues credit-checked PIFO pops and steers responses
// into per-port output buffers, with per-port backoff after a miss.
module pifo_pop_sched
  import pifo_pop_sched_pkg::*;
#(
  parameter int NUMPORT = 2,
  parameter int BITPORT = 1,
  parameter int BITPRIO = PRIORITY_BITS,
  parameter int BITDATA = ELEMENT_BITS,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int BACKOFF = DEF_BACKOFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMPORT-1:0]         port_en,
  pifo_pop_sched_if.master           pif,
  output logic [NUMPORT-1:0]         out_vld,
  input  logic [NUMPORT-1:0]         out_rdy,
  output logic [NUMPORT*BITPRIO-1:0] out_pri,
  output logic [NUMPORT*BITDATA-1:0] out_data,
  output logic [CNT_W-1:0]           pop_cnt,
  output logic [CNT_W-1:0]           miss_cnt,
  output logic                       err
);
  localparam int OCW = $clog2(DEPTH) + 1;
  localparam int BOW = $clog2(BACKOFF + 1);
  localparam int EW  = BITPRIO + BITDATA;

  logic [NUMPORT-1:0][OCW-1:0] w_occ;
  logic [NUMPORT-1:0][EW-1:0]  w_head;
  logic [NUMPORT-1:0][BOW-1:0] r_bo;
  logic [NUMPORT-1:0]          w_elig, w_wr;
  logic [BITPORT-1:0]          r_rr, r_prt, w_gnt;
  logic                        r_iss, w_any;

  // A pop in flight holds a slot so the buffer never overflows on its response.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < NUMPORT; p++)
      w_elig[p] = port_en[p] && (r_bo[p] == '0) &&
                  ((int'(w_occ[p]) + int'(r_iss && (r_prt == BITPORT'(p)))) < DEPTH);
  end

  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NUMPORT; k++) begin
      if (!w_any && w_elig[(int'(r_rr) + k) % NUMPORT]) begin
        w_any = 1'b1;
        w_gnt = BITPORT'((int'(r_rr) + k) % NUMPORT);
      end
    end
  end

  assign pif.pop_0  = w_any && !rst;
  assign pif.oprt_0 = pif.pop_0 ? w_gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss    <= 1'b0;
      r_prt    <= '0;
      r_rr     <= '0;
      r_bo     <= '0;
      pop_cnt  <= '0;
      miss_cnt <= '0;
      err      <= 1'b0;
    end else begin
      r_iss <= pif.pop_0;
      r_prt <= pif.oprt_0;
      if (w_any) r_rr <= (int'(w_gnt) == NUMPORT - 1) ? '0 : w_gnt + 1'b1;
      for (int p = 0; p < NUMPORT; p++) begin
        if (r_iss && !pif.ovld_0 && (r_prt == BITPORT'(p))) r_bo[p] <= BOW'(BACKOFF);
        else if (r_bo[p] != '0)                              r_bo[p] <= r_bo[p] - 1'b1;
      end
      if (r_iss && pif.ovld_0)  pop_cnt  <= sat_inc(pop_cnt);
      if (r_iss && !pif.ovld_0) miss_cnt <= sat_inc(miss_cnt);
      if (!r_iss && pif.ovld_0) err      <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUMPORT; p++) begin : g_port
    assign w_wr[p] = r_iss && pif.ovld_0 && (r_prt == BITPORT'(p));

    pifo_out_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_wr[p]),
      .i_wdata ({pif.opri_0, pif.odout_0}),
      .i_rd    (out_rdy[p]),
      .o_vld   (out_vld[p]),
      .o_rdata (w_head[p]),
      .o_occ   (w_occ[p])
    );

    assign out_pri[p*BITPRIO +: BITPRIO]  = w_head[p][BITDATA +: BITPRIO];
    assign out_data[p*BITDATA +: BITDATA] = w_head[p][BITDATA-1:0];
  end
endmodule

// File: tb/tb_pifo_pop_sched.sv
// Scheduler bench: bench-side PIFO plus a queue-based model of buffers, backoff and arbitration.
module tb_pifo_pop_sched;
  import pifo_pop_sched_pkg::*;

  localparam int NP  = 2;
  localparam int BP  = 1;
  localparam int PW  = PRIORITY_BITS;
  localparam int DW  = ELEMENT_BITS;
  localparam int DEP = DEF_DEPTH;
  localparam int BO  = DEF_BACKOFF;
  localparam int EW  = PW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_en, out_vld, out_rdy;
  logic [NP*PW-1:0]  out_pri;
  logic [NP*DW-1:0]  out_data;
  logic [31:0]       pop_cnt, miss_cnt;
  logic              err;

  pifo_pop_sched_if #(.BITPORT(BP), .BITPRIO(PW), .BITDATA(DW)) pif ();

  pifo_pop_sched #(
    .NUMPORT(NP), .BITPORT(BP), .BITPRIO(PW), .BITDATA(DW), .DEPTH(DEP), .BACKOFF(BO)
  ) dut (
    .clk(clk), .rst(rst), .port_en(port_en), .pif(pif),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pri(out_pri), .out_data(out_data),
    .pop_cnt(pop_cnt), .miss_cnt(miss_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] pifo_q [NP][$];
  logic [EW-1:0] mq     [NP][$];
  int      bo [NP];
  int      rr, m_port, cyc;
  bit      m_iss, m_err, pend, spur;
  int      pend_port;
  longint  m_pop, m_miss;
  int      log_port[$];
  int      log_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      bo[p] = 0;
      mq[p].delete();
    end
    rr = 0; m_iss = 0; m_port = 0; m_err = 0; m_pop = 0; m_miss = 0;
  endtask

  task automatic load(input int p, input int n);
    for (int i = 0; i < n; i++) pifo_q[p].push_back(EW'($urandom));
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    int g, idx, infl;
    logic [EW-1:0] e;
    if (pend) begin
      if (pifo_q[pend_port].size() > 0) begin
        e = pifo_q[pend_port].pop_front();
        pif.ovld_0 = 1'b1;
        {pif.opri_0, pif.odout_0} = e;
      end else begin
        pif.ovld_0 = 1'b0;
        {pif.opri_0, pif.odout_0} = EW'($urandom);
      end
    end else begin
      pif.ovld_0 = spur;
      {pif.opri_0, pif.odout_0} = EW'($urandom);
    end
    #1;
    g = -1;
    for (int k = 0; k < NP; k++) begin
      idx  = (rr + k) % NP;
      infl = (m_iss && m_port == idx) ? 1 : 0;
      if (g < 0 && port_en[idx] && bo[idx] == 0 && (mq[idx].size() + infl) < DEP) g = idx;
    end
    chk("pop_0", pif.pop_0, (!rst && g >= 0));
    chk("oprt_0", pif.oprt_0, (!rst && g >= 0) ? g : 0);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("out_vld[%0d]", p), out_vld[p], mq[p].size() != 0);
      if (mq[p].size() != 0) begin
        e = mq[p][0];
        chk($sformatf("out_pri[%0d]", p), out_pri[p*PW +: PW], e[EW-1 -: PW]);
        chk($sformatf("out_data[%0d]", p), out_data[p*DW +: DW], e[DW-1:0]);
      end
    end
    chk("pop_cnt", pop_cnt, m_pop);
    chk("miss_cnt", miss_cnt, m_miss);
    chk("err", err, m_err);

    if (pif.pop_0) begin
      log_port.push_back(int'(pif.oprt_0));
      log_cyc.push_back(cyc);
    end
    pend = pif.pop_0;
    pend_port = int'(pif.oprt_0);

    if (rst) model_reset();
    else begin
      for (int p = 0; p < NP; p++) begin
        if (out_rdy[p] && mq[p].size() > 0) e = mq[p].pop_front();
        if (bo[p] > 0) bo[p]--;
      end
      if (m_iss) begin
        if (pif.ovld_0) begin
          mq[m_port].push_back({pif.opri_0, pif.odout_0});
          if (m_pop < 64'hFFFF_FFFF) m_pop++;
        end else begin
          bo[m_port] = BO;
          if (m_miss < 64'hFFFF_FFFF) m_miss++;
        end
      end else if (pif.ovld_0) m_err = 1;
      m_iss = (g >= 0);
      if (g >= 0) begin
        m_port = g;
        rr = (g + 1) % NP;
      end
    end
    spur = 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) pifo_q[p].delete();
    log_port.delete();
    log_cyc.delete();
  endtask

  initial begin
    int exp038 [6] = '{0, 1, 0, 1, 0, 1};
    int c1, c2;
    logic [EW-1:0] first0;
    rst = 1'b1; port_en = '0; out_rdy = '0; spur = 0; pend = 0; pend_port = 0; cyc = 0;
    pif.ovld_0 = 1'b0; pif.opri_0 = '0; pif.odout_0 = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_pop_cnt", pop_cnt, 0);
    chk("rst_err", err, 0);

    // Both ports, 3 elements each: strict alternation
    load(0, 3); load(1, 3);
    port_en = 2'b11; out_rdy = 2'b11;
    repeat (10) step();
    for (int i = 0; i < 6; i++)
      chk("alt_order", (i < log_port.size()) ? log_port[i] : -1, exp038[i]);
    chk("alt_pop_cnt", pop_cnt, 6);

    // Stalled consumer: credit limits to DEPTH pops
    do_reset();
    load(0, 10);
    first0 = pifo_q[0][0];
    port_en = 2'b01; out_rdy = 2'b00;
    repeat (15) step();
    chk("stall_pops", log_port.size(), 4);
    chk("stall_pop_cnt", pop_cnt, 4);
    chk("stall_pifo_left", pifo_q[0].size(), 6);
    chk("stall_head", {out_pri[PW-1:0], out_data[DW-1:0]}, first0);

    // One-cycle ready pulse on a full buffer, then drain
    out_rdy = 2'b01;
    step();
    out_rdy = 2'b00;
    repeat (3) step();
    chk("pulse_pop_cnt", pop_cnt, 5);
    chk("pulse_vld", out_vld[0], 1);
    out_rdy = 2'b01;
    repeat (30) step();
    chk("drain_pop_cnt", pop_cnt, 10);
    chk("drain_pifo_left", pifo_q[0].size(), 0);

    // Miss and backoff on port 1
    do_reset();
    load(0, 20);
    port_en = 2'b11; out_rdy = 2'b11;
    repeat (4) step();
    chk("miss_cnt_one", miss_cnt, 1);
    repeat (12) step();
    c1 = -1; c2 = -1;
    foreach (log_port[i]) begin
      if (log_port[i] == 1) begin
        if (c1 < 0) c1 = log_cyc[i];
        else if (c2 < 0) c2 = log_cyc[i];
      end
    end
    chk("backoff_gap", (c1 >= 0 && c2 >= 0 && (c2 - c1) >= 5), 1);

    // Reset with a pop in flight, then a stray response after release
    do_reset();
    load(0, 2); load(1, 2);
    port_en = 2'b11; out_rdy = 2'b11;
    step();
    chk("inflight_issue", log_port.size(), 1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0; port_en = 2'b00;
    chk("rstdrop_err", err, 0);
    chk("rstdrop_pop_cnt", pop_cnt, 0);
    chk("rstdrop_out_vld", out_vld, 0);
    spur = 1;
    step();
    chk("stray_err", err, 1);

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NP; p++) begin
        port_en[p] = ($urandom_range(0, 7) != 0);
        out_rdy[p] = $urandom_range(0, 1);
        if (pifo_q[p].size() < 3 && $urandom_range(0, 3) == 0) load(p, $urandom_range(1, 5));
      end
      if (!pend && $urandom_range(0, 299) == 0) spur = 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
